// File: rtl/fetch_pipe.sv
// fetch_pipe: instruction-fetch stage with its own instruction memory, a
// program-load write port, and the F->D pipeline register that feeds decode.
// The hazard unit steers it through stall_f / stall_d / flush_d, and execute
// redirects it through pc_select_e / pc_branch_e.
// IMEM_DEPTH must be at least 2, and XLEN must be at least log2(IMEM_DEPTH).
module fetch_pipe #(
    parameter int XLEN       = 16,
    parameter int IMEM_DEPTH = 1024,
    parameter int RESET_PC   = 0,
    parameter int PC_STEP    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pc_select_e,
    input  logic [XLEN-1:0]               pc_branch_e,
    input  logic                          stall_f,
    input  logic                          stall_d,
    input  logic                          flush_d,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [XLEN-1:0]               imem_wdata,
    output logic [XLEN-1:0]               pc_f,
    output logic [XLEN-1:0]               pc_d,
    output logic [XLEN-1:0]               pc_next_d,
    output logic [XLEN-1:0]               instr_d,
    output logic                          valid_d,
    output logic                          misalign_d
);

    localparam int AW    = $clog2(IMEM_DEPTH);
    localparam int SHIFT = $clog2(PC_STEP);

    localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(PC_STEP - 1);
    localparam logic [XLEN-1:0] PC_INIT    = XLEN'(RESET_PC);

    logic [XLEN-1:0] mem [IMEM_DEPTH];

    logic [XLEN-1:0] pc_plus_step;
    logic [AW-1:0]   rd_index;
    logic [XLEN-1:0] rd_data;
    logic            pc_misaligned;

    // The low PC bits below the step size are dropped to form the word
    // index, and the upper bits fall off the truncation, so fetch wraps
    // around the memory. Misalignment is only reported, never trapped.
    assign pc_plus_step  = pc_f + STEP;
    assign rd_index      = AW'(pc_f >> SHIFT);
    assign rd_data       = mem[rd_index];
    assign pc_misaligned = (pc_f & ALIGN_MASK) != '0;

    // Program-load port; memory contents survive reset, and a same-cycle
    // read of the written word still sees the previous contents.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            mem[imem_waddr] <= imem_wdata;
        end
    end

    // Fetch PC: reset, then redirect (which beats a stall), then hold, then step.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_f <= PC_INIT;
        end else if (pc_select_e) begin
            pc_f <= pc_branch_e;
        end else if (!stall_f) begin
            pc_f <= pc_plus_step;
        end
    end

    // F->D register: reset, then bubble on redirect/flush, then hold, then capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_d       <= '0;
            pc_next_d  <= '0;
            instr_d    <= '0;
            valid_d    <= 1'b0;
            misalign_d <= 1'b0;
        end else if (pc_select_e || flush_d) begin
            pc_d       <= '0;
            pc_next_d  <= '0;
            instr_d    <= '0;
            valid_d    <= 1'b0;
            misalign_d <= 1'b0;
        end else if (!stall_d) begin
            pc_d       <= pc_f;
            pc_next_d  <= pc_plus_step;
            instr_d    <= rd_data;
            valid_d    <= 1'b1;
            misalign_d <= pc_misaligned;
        end
    end

endmodule

// File: tb/tb_fetch_pipe.sv
// tb_fetch_pipe: directed test of fetch_pipe with its default parameters
// (16-bit PC, 1024 words, reset PC 0, step 2). The memory is loaded through
// the write port while reset is held, then the pipeline is steered through
// sequential fetch, stalls, redirects, flushes, wrap, misalignment, the load
// port, and a mid-run reset.
module tb_fetch_pipe;

    logic        clk;
    logic        rst;
    logic        pc_select_e;
    logic [15:0] pc_branch_e;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        imem_we;
    logic [9:0]  imem_waddr;
    logic [15:0] imem_wdata;
    logic [15:0] pc_f;
    logic [15:0] pc_d;
    logic [15:0] pc_next_d;
    logic [15:0] instr_d;
    logic        valid_d;
    logic        misalign_d;

    int total;
    int bad;

    fetch_pipe #(
        .XLEN       (16),
        .IMEM_DEPTH (1024),
        .RESET_PC   (0),
        .PC_STEP    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_select_e (pc_select_e),
        .pc_branch_e (pc_branch_e),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .pc_f        (pc_f),
        .pc_d        (pc_d),
        .pc_next_d   (pc_next_d),
        .instr_d     (instr_d),
        .valid_d     (valid_d),
        .misalign_d  (misalign_d)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle just past it before checking or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive every control input in one step.
    task automatic applyStimulus(input logic r, input logic sel, input logic [15:0] target,
                                 input logic sf, input logic sd, input logic fl);
        rst         = r;
        pc_select_e = sel;
        pc_branch_e = target;
        stall_f     = sf;
        stall_d     = sd;
        flush_d     = fl;
    endtask

    // One comparison of one output field.
    task automatic checkField(input string tag, input string field,
                              input logic [15:0] observed, input logic [15:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, field, observed, expected);
        end
    endtask

    // Compare all six outputs against hand-computed values.
    task automatic checkOutput(input string tag, input logic [15:0] e_pc_f,
                               input logic [15:0] e_pc_d, input logic [15:0] e_pc_next,
                               input logic [15:0] e_instr, input logic e_valid,
                               input logic e_misalign);
        checkField(tag, "pc_f",       pc_f,              e_pc_f);
        checkField(tag, "pc_d",       pc_d,              e_pc_d);
        checkField(tag, "pc_next_d",  pc_next_d,         e_pc_next);
        checkField(tag, "instr_d",    instr_d,           e_instr);
        checkField(tag, "valid_d",    {15'd0, valid_d},    {15'd0, e_valid});
        checkField(tag, "misalign_d", {15'd0, misalign_d}, {15'd0, e_misalign});
    endtask

    // Directed sequence; memory map: word 0..3 = 1111..4444, word i (4..15) = 1000+i,
    // word 0x20 = AAAA, word 0x3FF = FFEE.
    initial begin
        total = 0;
        bad   = 0;
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        imem_we    = 1'b0;
        imem_waddr = '0;
        imem_wdata = '0;

        // Load the program while reset is held.
        imem_we = 1'b1;
        for (int i = 0; i < 16; i++) begin
            imem_waddr = 10'(i);
            imem_wdata = (i < 4) ? 16'(16'h1111 * (i + 1)) : 16'(16'h1000 + i);
            tick();
        end
        imem_waddr = 10'h020;
        imem_wdata = 16'hAAAA;
        tick();
        imem_waddr = 10'h3FF;
        imem_wdata = 16'hFFEE;
        tick();
        imem_we = 1'b0;
        checkOutput("reset", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);

        // Sequential fetch after reset release.
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick(); checkOutput("seq1", 16'h0002, 16'h0000, 16'h0002, 16'h1111, 1'b1, 1'b0);
        tick(); checkOutput("seq2", 16'h0004, 16'h0002, 16'h0004, 16'h2222, 1'b1, 1'b0);
        tick(); checkOutput("seq3", 16'h0006, 16'h0004, 16'h0006, 16'h3333, 1'b1, 1'b0);
        tick(); checkOutput("seq4", 16'h0008, 16'h0006, 16'h0008, 16'h4444, 1'b1, 1'b0);

        // Three-cycle stall of both stages, then resume at the next PC.
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(); checkOutput("stall", 16'h0008, 16'h0006, 16'h0008, 16'h4444, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick(); checkOutput("resume", 16'h000A, 16'h0008, 16'h000A, 16'h1004, 1'b1, 1'b0);

        // Redirect to 0x0040.
        applyStimulus(1'b1, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b0);
        tick(); checkOutput("redir_bubble", 16'h0040, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick(); checkOutput("redir_target", 16'h0042, 16'h0040, 16'h0042, 16'hAAAA, 1'b1, 1'b0);

        // Redirect while both stages are stalled: the redirect wins.
        applyStimulus(1'b1, 1'b1, 16'h000C, 1'b1, 1'b1, 1'b0);
        tick(); checkOutput("redir_stall", 16'h000C, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick(); checkOutput("redir_stall_tgt", 16'h000E, 16'h000C, 16'h000E, 16'h1006, 1'b1, 1'b0);

        // Flush together with stall_d: the bubble wins, fetch keeps stepping.
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        tick(); checkOutput("flush_stall", 16'h0010, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick(); checkOutput("after_flush", 16'h0012, 16'h0010, 16'h0012, 16'h1008, 1'b1, 1'b0);

        // Wrap from the top of the address space.
        applyStimulus(1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        tick(); checkOutput("wrap_redir", 16'hFFFE, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick(); checkOutput("wrap_top", 16'h0000, 16'hFFFE, 16'h0000, 16'hFFEE, 1'b1, 1'b0);
        tick(); checkOutput("wrap_zero", 16'h0002, 16'h0000, 16'h0002, 16'h1111, 1'b1, 1'b0);

        // Misaligned target: low bit dropped for the index, flag raised.
        applyStimulus(1'b1, 1'b1, 16'h0013, 1'b0, 1'b0, 1'b0);
        tick(); checkOutput("mis_redir", 16'h0013, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick(); checkOutput("mis_first", 16'h0015, 16'h0013, 16'h0015, 16'h1009, 1'b1, 1'b1);
        tick(); checkOutput("mis_second", 16'h0017, 16'h0015, 16'h0017, 16'h100A, 1'b1, 1'b1);

        // Write word 5 while fetching PC 0x000A: D still gets the old word.
        applyStimulus(1'b1, 1'b1, 16'h000A, 1'b0, 1'b0, 1'b0);
        tick(); checkOutput("wr_redir", 16'h000A, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        imem_we    = 1'b1;
        imem_waddr = 10'd5;
        imem_wdata = 16'hBEEF;
        tick(); checkOutput("wr_same_cycle", 16'h000C, 16'h000A, 16'h000C, 16'h1005, 1'b1, 1'b0);
        imem_we = 1'b0;
        applyStimulus(1'b1, 1'b1, 16'h000A, 1'b0, 1'b0, 1'b0);
        tick(); checkOutput("refetch_redir", 16'h000A, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick(); checkOutput("refetch_new", 16'h000C, 16'h000A, 16'h000C, 16'hBEEF, 1'b1, 1'b0);

        // Mid-run reset during a stall, with a redirect also pending.
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        tick(); checkOutput("pre_reset_hold", 16'h000C, 16'h000A, 16'h000C, 16'hBEEF, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0040, 1'b1, 1'b1, 1'b0);
        tick(); checkOutput("mid_reset", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);

        // Memory survives reset: first edge after release fetches word 0.
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick(); checkOutput("post_reset", 16'h0002, 16'h0000, 16'h0002, 16'h1111, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
